// File: rtl/wide_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module : wide_arith_pkg
// Brief  : Shared types, defaults and helpers for the wide-arithmetic datapath.
// Rev    : 1.0 - initial release
// ============================================================================
package wide_arith_pkg;

    localparam int C_WIDE_WIDTH = 100;
    localparam int C_WIDE_CHUNK = 16;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_RUN  = 2'd1,
        WS_DONE = 2'd2
    } ws_state_t;

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wide_sub_seq_if.sv
`default_nettype none
// ============================================================================
// Module : wide_sub_seq_if
// Brief  : Operand/result valid-ready bundle for wide_sub_seq.
//          The zero flag exists only when WIDE_SUB_FLAGS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
interface wide_sub_seq_if
    import wide_arith_pkg::*;
#(
    parameter int WIDTH = C_WIDE_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef WIDE_SUB_FLAGS_EN
    logic             zero;

    modport master (output in_valid, x, y, out_ready,
                    input  in_ready, out_valid, diff, borrow, zero);
    modport slave  (input  in_valid, x, y, out_ready,
                    output in_ready, out_valid, diff, borrow, zero);
`else
    modport master (output in_valid, x, y, out_ready,
                    input  in_ready, out_valid, diff, borrow);
    modport slave  (input  in_valid, x, y, out_ready,
                    output in_ready, out_valid, diff, borrow);
`endif
endinterface
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module : sub_chunk
// Brief  : Combinational CHUNK-bit subtract with borrow-in and borrow-out.
// Rev    : 1.0 - initial release
// ============================================================================
module sub_chunk
    import wide_arith_pkg::*;
#(
    parameter int CHUNK = C_WIDE_CHUNK
) (
    input  wire logic [CHUNK-1:0] i_a,
    input  wire logic [CHUNK-1:0] i_b,
    input  wire logic             i_bin,
    output logic      [CHUNK-1:0] o_d,
    output logic                  o_bout
);
    // The extra top bit of the widened difference is the borrow out.
    assign {o_bout, o_d} = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
endmodule
`default_nettype wire

// File: rtl/wide_sub_seq.sv
`default_nettype none
// ============================================================================
// Module : wide_sub_seq
// Brief  : Multi-cycle wide subtractor, CHUNK bits per cycle, registered borrow.
//          Optional zero flag enabled by WIDE_SUB_FLAGS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module wide_sub_seq
    import wide_arith_pkg::*;
#(
    parameter int WIDTH = C_WIDE_WIDTH,
    parameter int CHUNK = C_WIDE_CHUNK
) (
    input  wire logic     clk,
    input  wire logic     rst,
    wide_sub_seq_if.slave bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCHUNK - 1);

    ws_state_t        r_state;
    ws_state_t        w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic [PADW-1:0]  r_x;
    logic [PADW-1:0]  r_y;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CHUNK-1:0] w_xc;
    logic [CHUNK-1:0] w_yc;
    logic [CHUNK-1:0] w_dc;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_accept = w_in_ready && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            WS_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = WS_RUN;
            end
            WS_RUN: begin
                if (w_last) w_state_nxt = WS_DONE;
            end
            WS_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = WS_IDLE;
            end
            default: w_state_nxt = WS_IDLE;
        endcase
    end

    // Operands are zero-padded to whole chunks, so the last chunk's borrow
    // equals the borrow out of bit WIDTH-1.
    always_comb begin
        w_xc = '0;
        w_yc = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_xc = r_x[i*CHUNK +: CHUNK];
                w_yc = r_y[i*CHUNK +: CHUNK];
            end
        end
    end

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .i_a    (w_xc),
        .i_b    (w_yc),
        .i_bin  (r_borrow),
        .o_d    (w_dc),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_x      <= PADW'(bus.x);
            r_y      <= PADW'(bus.y);
            r_borrow <= 1'b0;
        end else if (r_state == WS_RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                for (int j = 0; j < CHUNK; j++) begin
                    if ((r_idx == IDXW'(i)) && (i*CHUNK + j < WIDTH)) begin
                        r_diff[i*CHUNK + j] <= w_dc[j];
                    end
                end
            end
            r_borrow <= w_bout;
            r_idx    <= w_last ? '0 : r_idx + 1'b1;
        end
    end

`ifdef WIDE_SUB_FLAGS_EN
    logic r_zero;

    // Padding bits can only go nonzero on a final borrow, which already
    // implies a nonzero in-width result, so the whole chunk is tested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b1;
        end else if (r_state == WS_RUN) begin
            r_zero <= r_zero && (w_dc == '0);
        end
    end

    assign bus.zero = r_zero;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_wide_sub_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_wide_sub_seq
// Brief  : Self-checking bench for wide_sub_seq: directed table, backpressure,
//          mid-run reset and randomized operands against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_wide_sub_seq;

    localparam int W   = 100;
    localparam int LAT = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wide_sub_seq_if #(.WIDTH(W)) bus ();

    wide_sub_seq #(
        .WIDTH (W),
        .CHUNK (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic       b;
        logic       z;
    } vec_t;

    task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // One full transaction; during 'hold' DONE cycles new operands are offered.
    task automatic run_op(input string nm, input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic [W-1:0] ed, input logic eb, input logic ez,
                          input int hold);
        int cyc;
        @(negedge clk);
        chk_b({nm, ".in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.x        = xa;
        bus.y        = ya;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x        = rnd();
        bus.y        = rnd();
        chk_b({nm, ".in_ready_run"}, bus.in_ready, 1'b0);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk_i({nm, ".latency"}, cyc, LAT);
        chk_w({nm, ".diff"}, bus.diff, ed);
        chk_b({nm, ".borrow"}, bus.borrow, eb);
`ifdef WIDE_SUB_FLAGS_EN
        chk_b({nm, ".zero"}, bus.zero, ez);
`else
        if (ez === 1'bx) $display("unreachable");
`endif
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            bus.x        = rnd();
            bus.y        = rnd();
            @(negedge clk);
            chk_b({nm, ".hold_valid"}, bus.out_valid, 1'b1);
            chk_b({nm, ".hold_in_ready"}, bus.in_ready, 1'b0);
            chk_w({nm, ".hold_diff"}, bus.diff, ed);
            chk_b({nm, ".hold_borrow"}, bus.borrow, eb);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk_b({nm, ".in_ready_after"}, bus.in_ready, 1'b1);
        chk_b({nm, ".out_valid_after"}, bus.out_valid, 1'b0);
    endtask

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] xr, yr;
        logic [W:0]   full;
        logic         seen;

        tbl[0] = '{"x2_y1",     100'd2, 100'd1, 100'd1, 1'b0, 1'b0};
        tbl[1] = '{"x1_y2",     100'd1, 100'd2, {W{1'b1}}, 1'b1, 1'b0};
        tbl[2] = '{"ripple64",  100'h1_0000_0000_0000_0000, 100'd1,
                   100'h0_ffff_ffff_ffff_ffff, 1'b0, 1'b0};
        tbl[3] = '{"equal",     100'hbeef_f00d, 100'hbeef_f00d, 100'd0, 1'b0, 1'b1};
        tbl[4] = '{"top_chunk", {1'b1, 99'd0}, {1'b1, 99'd5},
                   {W{1'b1}} - 100'd4, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        repeat (2) @(negedge clk);
        chk_b("reset.in_ready", bus.in_ready, 1'b1);
        chk_b("reset.out_valid", bus.out_valid, 1'b0);
        chk_w("reset.diff", bus.diff, '0);
        chk_b("reset.borrow", bus.borrow, 1'b0);
`ifdef WIDE_SUB_FLAGS_EN
        chk_b("reset.zero", bus.zero, 1'b0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].b, tbl[i].z, 0);

        // Backpressure with new operands offered while the result is held.
        run_op("backpressure", 100'd1, 100'd2, {W{1'b1}}, 1'b1, 1'b0, 5);

        // Reset in the third RUN cycle aborts the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = 100'd5;
        bus.y        = 100'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_b("abort.in_ready", bus.in_ready, 1'b1);
        chk_b("abort.out_valid", bus.out_valid, 1'b0);
        chk_w("abort.diff", bus.diff, '0);
        chk_b("abort.borrow", bus.borrow, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk_b("abort.no_result", seen, 1'b0);
        run_op("after_abort", 100'd7, 100'd3, 100'd4, 1'b0, 1'b0, 0);

        // Random operands against plain (W+1)-bit arithmetic.
        for (int n = 0; n < 40; n++) begin
            xr = rnd();
            case ($urandom_range(0, 3))
                0:       yr = xr;
                1:       yr = W'($urandom_range(0, 20));
                default: yr = rnd();
            endcase
            full = {1'b0, xr} - {1'b0, yr};
            run_op($sformatf("rand%0d", n), xr, yr, full[W-1:0], full[W],
                   (full[W-1:0] == '0), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
